wave_sched: RTL and testbench

Round-robin scheduler that shares one low-high-low burst generator among N_REQ requesters. Each requester raises `req` to ask for one burst. The block arbitrates among pending requests, drives the shared waveform line with the programmed LOW1/HIGH/LOW2 phase lengths, and returns a per-requester `done` pulse. It sits between the test-stimulus control logic and the pad that drives the burst line; the pad resolves tri-state from `wave_oe`.

---
 rtl/wave_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/wave_sched.sv | 160 ++++++++++++++++
 tb/tb_wave_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_sched_pkg.sv
// Shared definitions for the wave_sched burst scheduler: FSM state type,
// requester-index width helper and default phase lengths.
package wave_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLow1,
        StHigh,
        StLow2,
        StGap
    } wave_state_e;

    localparam int unsigned DefNReq    = 4;
    localparam int unsigned DefLow1Len = 200;
    localparam int unsigned DefHighLen = 100;
    localparam int unsigned DefLow2Len = 200;
    localparam int unsigned DefGapLen  = 16;
    localparam int unsigned DefCntW    = 16;

    // Width of an index into n requesters (at least one bit)
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending requester at or
// after (last_i + 1) mod N_REQ. The last-grant pointer is held by the caller.
module rr_arbiter
    import wave_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             valid_o
);

    logic [ID_W-1:0] idx;

    // Rotating priority search; the first hit in search order wins
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        valid_o    = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_i) + k) % N_REQ);
            if (!valid_o && pending_i[idx]) begin
                valid_o      = 1'b1;
                grant_id_o   = idx;
                grant_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sched.sv
// Round-robin scheduler sharing one low-high-low burst generator among N_REQ
// requesters. Optional guard gap after each burst: define WAVE_SCHED_GAP_EN.
module wave_sched
    import wave_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = DefNReq,
    parameter int unsigned LOW1_LEN = DefLow1Len,
    parameter int unsigned HIGH_LEN = DefHighLen,
    parameter int unsigned LOW2_LEN = DefLow2Len,
    parameter int unsigned GAP_LEN  = DefGapLen,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic [id_w(N_REQ)-1:0]  grant_id,
    output logic                    wave_out,
    output logic                    wave_oe
);

    localparam int unsigned ID_W = id_w(N_REQ);

    // Elaboration-time parameter sanity
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("wave_sched: N_REQ must be in 2..8");
    end
    if (LOW1_LEN == 0 || HIGH_LEN == 0 || LOW2_LEN == 0 || GAP_LEN == 0) begin : g_bad_len
        $error("wave_sched: phase lengths must be at least 1");
    end
    if (CNT_W < 32 && ((((LOW1_LEN - 1) >> CNT_W) != 0) || (((HIGH_LEN - 1) >> CNT_W) != 0) ||
                       (((LOW2_LEN - 1) >> CNT_W) != 0) || (((GAP_LEN - 1) >> CNT_W) != 0)))
    begin : g_bad_cnt_w
        $error("wave_sched: CNT_W too narrow for a phase length");
    end

    localparam logic [CNT_W-1:0] Low1Last = CNT_W'(LOW1_LEN - 1);
    localparam logic [CNT_W-1:0] HighLast = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0] Low2Last = CNT_W'(LOW2_LEN - 1);
`ifdef WAVE_SCHED_GAP_EN
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_LEN - 1);
`endif

    wave_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] req_d_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] clr;

    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_id;
    logic             arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .pending_i  (pending_q),
        .last_i     (last_q),
        .grant_o    (arb_grant),
        .grant_id_o (arb_id),
        .valid_o    (arb_valid)
    );

    // Pending bits: new rising edge wins over a same-cycle grant clear
    always_comb begin
        pending_d = (pending_q & ~clr) | (req & ~req_d_q);
    end

    // Burst FSM next-state, phase counter, grant bookkeeping and done pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        done_d     = '0;
        clr        = '0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (arb_valid) begin
                    state_d    = StLow1;
                    grant_id_d = arb_id;
                    last_d     = arb_id;
                    clr        = arb_grant;
                end
            end
            StLow1: begin
                if (cnt_q == Low1Last) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end
            end
            StHigh: begin
                if (cnt_q == HighLast) begin
                    state_d = StLow2;
                    cnt_d   = '0;
                end
            end
            StLow2: begin
                if (cnt_q == Low2Last) begin
                    done_d = N_REQ'(1) << grant_id_q;
                    cnt_d  = '0;
`ifdef WAVE_SCHED_GAP_EN
                    state_d = StGap;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef WAVE_SCHED_GAP_EN
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset points the arbiter so requester 0 is searched first
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_d_q    <= '0;
            pending_q  <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            grant_id_q <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_d_q    <= req;
            pending_q  <= pending_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            done_q     <= done_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        wave_oe  = (state_q == StLow1) || (state_q == StHigh) || (state_q == StLow2);
        wave_out = (state_q == StHigh);
        busy     = (state_q != StIdle);
        done     = done_q;
        grant_id = grant_id_q;
    end

endmodule

// File: tb/tb_wave_sched.sv
// Self-checking bench for wave_sched. A negedge monitor pops expected
// requester ids from a scoreboard and checks every burst's shape and done.
module tb_wave_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned L1    = 4;
    localparam int unsigned HI    = 2;
    localparam int unsigned L2    = 3;
    localparam int unsigned GP    = 2;
    localparam int unsigned CW    = 4;
    localparam int          BURST = L1 + HI + L2;
`ifdef WAVE_SCHED_GAP_EN
    localparam int GAP_EXP      = GP + 1;
    localparam int GAP_BUSY_EXP = GP;
`else
    localparam int GAP_EXP      = 1;
    localparam int GAP_BUSY_EXP = 0;
`endif

    logic            clk_in = 1'b0;
    logic            rst    = 1'b0;
    logic [NREQ-1:0] req    = '0;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [1:0]      grant_id;
    logic            wave_out;
    logic            wave_oe;

    int errors = 0;
    int checks = 0;
    int sb[$];
    int burst_count   = 0;
    int pos           = -1;
    int cur_id        = 0;
    int rel_cnt       = 0;
    int rel_busy      = 0;
    int last_gap      = 0;
    int last_gap_busy = 0;

    wave_sched #(
        .N_REQ    (NREQ),
        .LOW1_LEN (L1),
        .HIGH_LEN (HI),
        .LOW2_LEN (L2),
        .GAP_LEN  (GP),
        .CNT_W    (CW)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .busy     (busy),
        .grant_id (grant_id),
        .wave_out (wave_out),
        .wave_oe  (wave_oe)
    );

    always #5 clk_in = ~clk_in;

    // Burst monitor: shape, length, grant id and done pulse against scoreboard
    always @(negedge clk_in) begin
        if (!rst) begin
            pos      = -1;
            rel_cnt  = 0;
            rel_busy = 0;
        end else if (wave_oe) begin
            if (pos < 0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_burst: grant_id=%0d, required no burst", grant_id);
                    cur_id = int'(grant_id);
                end else begin
                    cur_id = sb.pop_front();
                    if (grant_id !== 2'(cur_id)) begin
                        errors++;
                        $display("FAIL grant_id: got %0d, required %0d", grant_id, cur_id);
                    end
                end
                last_gap      = rel_cnt;
                last_gap_busy = rel_busy;
                pos           = 0;
            end
            checks += 3;
            if (wave_out !== ((pos >= L1) && (pos < L1 + HI))) begin
                errors++;
                $display("FAIL wave_shape: cycle %0d wave_out=%b", pos, wave_out);
            end
            if (done !== 4'b0) begin
                errors++;
                $display("FAIL done_in_burst: got %b, required 0000", done);
            end
            if (pos >= BURST) begin
                errors++;
                $display("FAIL burst_too_long: cycle %0d, required < %0d", pos, BURST);
            end
            pos++;
        end else begin
            if (pos >= 0) begin
                checks += 2;
                if (pos !== BURST) begin
                    errors++;
                    $display("FAIL burst_len: got %0d, required %0d", pos, BURST);
                end
                if (done !== (4'b1 << cur_id)) begin
                    errors++;
                    $display("FAIL done_pulse: got %b, required %b", done, 4'b1 << cur_id);
                end
                burst_count++;
                pos      = -1;
                rel_cnt  = 0;
                rel_busy = 0;
            end else begin
                checks++;
                if (done !== 4'b0) begin
                    errors++;
                    $display("FAIL done_idle: got %b, required 0000", done);
                end
            end
            checks++;
            if (wave_out !== 1'b0) begin
                errors++;
                $display("FAIL wave_out_released: got %b, required 0", wave_out);
            end
            rel_cnt++;
            if (busy) rel_busy++;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        sb.delete();
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_bursts(input int target, input int budget);
        int n;
        n = 0;
        while (burst_count < target && n < budget) begin
            @(posedge clk_in);
            n++;
        end
        checks++;
        if (burst_count < target) begin
            errors++;
            $display("FAIL wait_bursts: got %0d bursts, required %0d", burst_count, target);
        end
    endtask

    task automatic wait_high(input int budget);
        int n;
        n = 0;
        while (wave_out !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (wave_out !== 1'b1) begin
            errors++;
            $display("FAIL wait_high: wave_out=%b, required 1 within %0d cycles", wave_out, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        #2;
        checks += 2;
        if (wave_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: wave_oe=%b busy=%b, required 0 0", wave_oe, busy);
        end
        if (done !== 4'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outs: done=%b grant_id=%0d, required 0000 0", done, grant_id);
        end
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b1;
        repeat (8) @(negedge clk_in);
        checks += 2;
        if (busy !== 1'b0 || wave_oe !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b wave_oe=%b, required 0 0", busy, wave_oe);
        end
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL idle_grant_id: got %0d, required 0", grant_id);
        end
    endtask

    task automatic test_single();
        logic exp_oe;
        logic exp_busy;
        do_reset();
        req[0] = 1'b1;
        sb.push_back(0);
        @(posedge clk_in);  // first edge sampling req[0] high
        for (int n = 0; n <= BURST + 3; n++) begin
            @(negedge clk_in);
            exp_oe   = (n >= 1) && (n <= BURST);
            exp_busy = (n >= 1) && (n <= BURST + GAP_BUSY_EXP);
            checks += 3;
            if (wave_oe !== exp_oe) begin
                errors++;
                $display("FAIL single_oe: n=%0d got %b, required %b", n, wave_oe, exp_oe);
            end
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL single_busy: n=%0d got %b, required %b", n, busy, exp_busy);
            end
            if (done !== ((n == BURST + 1) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL single_done: n=%0d got %b", n, done);
            end
        end
        req = '0;
    endtask

    task automatic test_simultaneous();
        int base;
        do_reset();
        base = burst_count;
        req = 4'b0110;
        sb.push_back(1);
        sb.push_back(2);
        wait_bursts(base + 2, 100);
        checks += 2;
        if (last_gap !== GAP_EXP) begin
            errors++;
            $display("FAIL b2b_gap: got %0d released cycles, required %0d", last_gap, GAP_EXP);
        end
        if (last_gap_busy !== GAP_BUSY_EXP) begin
            errors++;
            $display("FAIL b2b_gap_busy: got %0d, required %0d", last_gap_busy, GAP_BUSY_EXP);
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int base;
        do_reset();
        base = burst_count;
        req = 4'b1111;
        sb.push_back(0);
        sb.push_back(1);
        sb.push_back(2);
        sb.push_back(3);
        for (int r = 0; r < 2; r++) begin
            wait_bursts(base + r + 1, 100);
            #1 req[r] = 1'b0;
            @(posedge clk_in);
            #1 req[r] = 1'b1;
            sb.push_back(r);
        end
        wait_bursts(base + 6, 200);
        // All requests still held high: no further bursts may appear
        repeat (40) @(posedge clk_in);
        #1;
        checks += 2;
        if (burst_count !== base + 6) begin
            errors++;
            $display("FAIL level_held: got %0d bursts, required %0d", burst_count - base, 6);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL level_held_busy: got %b, required 0", busy);
        end
        req = '0;
    endtask

    task automatic test_requeue();
        int base;
        do_reset();
        base = burst_count;
        req[3] = 1'b1;
        sb.push_back(3);
        wait_high(50);
        req[3] = 1'b0;
        @(negedge clk_in);
        req[3] = 1'b1;
        sb.push_back(3);
        wait_bursts(base + 2, 100);
        checks++;
        if (last_gap !== GAP_EXP) begin
            errors++;
            $display("FAIL requeue_gap: got %0d, required %0d", last_gap, GAP_EXP);
        end
        req = '0;
    endtask

    task automatic test_abort();
        int base;
        do_reset();
        base = burst_count;
        req[1] = 1'b1;
        sb.push_back(1);
        wait_high(50);
        req[2] = 1'b1;
        @(posedge clk_in);
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (wave_oe !== 1'b0 || wave_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_wave: wave_oe=%b wave_out=%b, required 0 0", wave_oe, wave_out);
        end
        if (busy !== 1'b0 || done !== 4'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b done=%b, required 0 0000", busy, done);
        end
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL abort_grant_id: got %0d, required 0", grant_id);
        end
        sb.delete();
        req = '0;
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b1;
        repeat (30) @(posedge clk_in);
        #1;
        checks += 2;
        if (burst_count !== base) begin
            errors++;
            $display("FAIL abort_lost: got %0d bursts, required 0", burst_count - base);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_requeue();
        test_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d expected bursts never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
